// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the CPU-to-SRAM bridge: state and source encodings,
// latency limits and a helper that turns a latency into a terminal count.
// Optional feature macro used elsewhere in this slice: BRIDGE_PERF_EN.
package mem_bridge_pkg;

  localparam int MAX_LATENCY = 15;
  localparam int LAT_W       = 4;

  // One-hot transaction states.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    WAIT = 3'b010,
    RESP = 3'b100
  } bridge_state_e;

  // Which CPU channel owns the outstanding read.
  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } bridge_src_e;

  // Terminal count for the latency counter; out-of-range latencies are clamped
  // to the legal 1..MAX_LATENCY window.
  function automatic logic [LAT_W-1:0] lat_last(input int lat);
    if (lat < 1)                return '0;
    else if (lat > MAX_LATENCY) return LAT_W'(MAX_LATENCY - 1);
    else                        return LAT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/bridge_lat_cnt.sv
// Latency counter for the bridge: cleared when a read is issued, advanced once
// per cycle while waiting, and flags when it sits on the terminal count.
module bridge_lat_cnt
  import mem_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [LAT_W-1:0] i_last,
  output logic [LAT_W-1:0] o_count,
  output logic             o_done
);

  logic [LAT_W-1:0] r_count;

  // Count register: clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with <= only, so every flop samples
    // pre-edge values regardless of the order blocks are evaluated in.
    if (!rst_n)     r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
  assign o_done  = (r_count == i_last);

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridge between the CPU fetch and data channels and one synchronous
// single-port SRAM. Data requests win over fetches; each read is returned on a
// valid/ready channel after MEM_LATENCY cycles and held until accepted.
// Define BRIDGE_PERF_EN to add the arbitration/response stall counters.
module cpu_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch channel
  input  logic [31:0]       inst_addr,
  input  logic              inst_req_valid,
  output logic              inst_req_ready,
  output logic [31:0]       inst_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  // data channel
  input  logic [31:0]       mem_addr,
  input  logic              mem_wen,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  input  logic              mem_ren,
  output logic              mem_req_ready,
  output logic [31:0]       mem_rdata,
  output logic              mem_rdata_valid,
  input  logic              mem_rdata_ready,
  // SRAM port
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
`ifdef BRIDGE_PERF_EN
  ,
  output logic [31:0]       arb_stall_cnt,
  output logic [31:0]       resp_stall_cnt
`endif
);

  localparam logic [LAT_W-1:0] LAT_LAST = lat_last(MEM_LATENCY);

  bridge_state_e    r_state;
  bridge_state_e    w_state_nxt;
  bridge_src_e      r_src;
  logic [31:0]      r_rbuf;

  logic             w_idle;
  logic             w_data_req;
  logic             w_data_fire;
  logic             w_inst_fire;
  logic             w_rd_fire;
  logic             w_in_wait;
  logic             w_in_resp;
  logic             w_resp_accept;
  logic [LAT_W-1:0] w_cnt;
  logic             w_cnt_done;
  logic             w_unused_addr_bits;

  // Requests are only considered in IDLE, and never while reset is asserted so
  // the SRAM strobes drop the moment rst_n falls.
  assign w_idle      = rst_n & (r_state == IDLE);
  assign w_data_req  = mem_wen | mem_ren;
  assign w_data_fire = w_idle & w_data_req;
  assign w_inst_fire = w_idle & inst_req_valid & ~w_data_req;
  // A store (even with mem_ren also set) produces no response.
  assign w_rd_fire   = w_inst_fire | (w_data_fire & ~mem_wen);

  assign w_in_wait   = (r_state == WAIT);
  assign w_in_resp   = (r_state == RESP);
  assign w_resp_accept = w_in_resp &
                         ((r_src == SRC_DATA) ? mem_rdata_ready : inst_ready);

  // Upper and byte-offset address bits deliberately take no part in the access.
  assign w_unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0],
                                inst_addr[31:ADDR_W+2], inst_addr[1:0]};

  bridge_lat_cnt u_lat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_rd_fire),
    .i_en    (w_in_wait),
    .i_last  (LAT_LAST),
    .o_count (w_cnt),
    .o_done  (w_cnt_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, arbitration and SRAM request decode.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    w_state_nxt    = r_state;
    inst_req_ready = 1'b0;
    mem_req_ready  = 1'b0;
    sram_en        = 1'b0;
    sram_we        = 4'b0000;
    sram_addr      = '0;
    sram_wdata     = '0;
    unique case (r_state)
      IDLE: begin
        if (rst_n) begin
          mem_req_ready  = w_data_req;
          inst_req_ready = inst_req_valid & ~w_data_req;
          if (w_data_req) begin
            sram_en   = 1'b1;
            sram_addr = mem_addr[ADDR_W+1:2];
            if (mem_wen) begin
              sram_we    = mem_wstrb;
              sram_wdata = mem_wdata;
            end else begin
              w_state_nxt = WAIT;
            end
          end else if (inst_req_valid) begin
            sram_en     = 1'b1;
            sram_addr   = inst_addr[ADDR_W+1:2];
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (w_cnt_done) w_state_nxt = RESP;
      end
      RESP: begin
        if (w_resp_accept) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Remember the requesting channel and capture the SRAM word on the first
  // wait cycle, when the 1-cycle SRAM read data is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src  <= SRC_INST;
      r_rbuf <= '0;
    end else begin
      if (w_rd_fire) r_src <= w_data_fire ? SRC_DATA : SRC_INST;
      if (w_in_wait && (w_cnt == '0)) r_rbuf <= sram_rdata;
    end
  end

  // Response channels: only the owning channel is valid; the other reads 0.
  assign inst_valid      = w_in_resp & (r_src == SRC_INST);
  assign mem_rdata_valid = w_in_resp & (r_src == SRC_DATA);
  assign inst_rdata      = inst_valid      ? r_rbuf : 32'h0;
  assign mem_rdata       = mem_rdata_valid ? r_rbuf : 32'h0;

`ifdef BRIDGE_PERF_EN
  // Stall counters: fetches denied by a data request in IDLE, and response
  // cycles the CPU left unaccepted. Both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_stall_cnt  <= '0;
      resp_stall_cnt <= '0;
    end else begin
      if (w_idle && inst_req_valid && w_data_req) arb_stall_cnt <= arb_stall_cnt + 32'd1;
      if (w_in_resp && !w_resp_accept)           resp_stall_cnt <= resp_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: SRAM model, behavioural reference
// (word array + one outstanding-read record), directed cases and random traffic.
// Define BRIDGE_PERF_EN to also exercise the stall counters.
module tb_cpu_mem_bridge;

  localparam int ADDR_W = 12;
  localparam int LAT    = 4;
  localparam int WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       inst_addr;
  logic              inst_req_valid;
  logic              inst_req_ready;
  logic [31:0]       inst_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       mem_addr;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ren;
  logic              mem_req_ready;
  logic [31:0]       mem_rdata;
  logic              mem_rdata_valid;
  logic              mem_rdata_ready;
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
`ifdef BRIDGE_PERF_EN
  logic [31:0]       arb_stall_cnt;
  logic [31:0]       resp_stall_cnt;
`endif

  cpu_mem_bridge #(.ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst_addr       (inst_addr),
    .inst_req_valid  (inst_req_valid),
    .inst_req_ready  (inst_req_ready),
    .inst_rdata      (inst_rdata),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .mem_addr        (mem_addr),
    .mem_wen         (mem_wen),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_ren         (mem_ren),
    .mem_req_ready   (mem_req_ready),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata_ready (mem_rdata_ready),
    .sram_en         (sram_en),
    .sram_we         (sram_we),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_rdata      (sram_rdata)
`ifdef BRIDGE_PERF_EN
    ,
    .arb_stall_cnt   (arb_stall_cnt),
    .resp_stall_cnt  (resp_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle = cycle + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no handshake within cycle budget (cycle %0d)", name, cycle);
  endtask

  // ---------------- SRAM model: read data valid only the cycle after en ----
  logic [31:0] sram_mem [WORDS];
  logic [31:0] sram_q;
  logic [31:0] sram_junk;
  logic        sram_rdv;

  always @(posedge clk) begin
    sram_junk <= $urandom;
    sram_rdv  <= sram_en && (sram_we == 4'b0000);
    if (sram_en) begin
      sram_q <= sram_mem[sram_addr];
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end
  assign sram_rdata = sram_rdv ? sram_q : sram_junk;

  // ---------------- reference model + per-cycle compare -------------------
  // NOTE: neither memory is cleared by rst_n; contents survive a bridge reset
  // exactly as a real SRAM would.
  logic [31:0] ref_mem [WORDS];
  bit          m_busy = 1'b0;
  bit          m_is_data;
  logic [31:0] m_data;
  int          m_valid_cycle;

  always @(negedge clk) begin
    logic        e_mrdy, e_irdy, e_vi, e_vm, data_req;
    logic [3:0]  e_we;
    int          idx;
    if (!rst_n) begin
      m_busy = 1'b0;
      check("rst_sram_en", sram_en, 0);
      check("rst_sram_we", sram_we, 0);
      check("rst_inst_req_ready", inst_req_ready, 0);
      check("rst_mem_req_ready", mem_req_ready, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_mem_rdata_valid", mem_rdata_valid, 0);
      check("rst_inst_rdata", inst_rdata, 0);
      check("rst_mem_rdata", mem_rdata, 0);
    end else begin
      data_req = mem_wen | mem_ren;
      e_mrdy   = !m_busy && data_req;
      e_irdy   = !m_busy && inst_req_valid && !data_req;
      e_vi     = m_busy && !m_is_data && (cycle >= m_valid_cycle);
      e_vm     = m_busy &&  m_is_data && (cycle >= m_valid_cycle);
      e_we     = (e_mrdy && mem_wen) ? mem_wstrb : 4'b0000;
      check("mem_req_ready", mem_req_ready, e_mrdy);
      check("inst_req_ready", inst_req_ready, e_irdy);
      check("sram_en", sram_en, e_mrdy | e_irdy);
      check("sram_we", sram_we, e_we);
      if (e_mrdy) check("sram_addr_data", sram_addr, mem_addr[ADDR_W+1:2]);
      if (e_irdy) check("sram_addr_inst", sram_addr, inst_addr[ADDR_W+1:2]);
      if (e_mrdy && mem_wen) check("sram_wdata", sram_wdata, mem_wdata);
      check("inst_valid", inst_valid, e_vi);
      check("mem_rdata_valid", mem_rdata_valid, e_vm);
      check("inst_rdata", inst_rdata, e_vi ? m_data : 32'h0);
      check("mem_rdata", mem_rdata, e_vm ? m_data : 32'h0);
      // effects of this cycle
      if (e_mrdy && mem_wen) begin
        idx = int'(mem_addr[ADDR_W+1:2]);
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) ref_mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
      end else if (e_mrdy) begin
        m_busy = 1'b1; m_is_data = 1'b1;
        m_data = ref_mem[int'(mem_addr[ADDR_W+1:2])];
        m_valid_cycle = cycle + LAT + 1;
      end else if (e_irdy) begin
        m_busy = 1'b1; m_is_data = 1'b0;
        m_data = ref_mem[int'(inst_addr[ADDR_W+1:2])];
        m_valid_cycle = cycle + LAT + 1;
      end else if ((e_vi && inst_ready) || (e_vm && mem_rdata_ready)) begin
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- driver helpers ----------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit fired = 0;
    mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_wen = 1'b1;
    for (int k = 0; k < 64 && !fired; k++) begin
      @(negedge clk);
      if (mem_req_ready === 1'b1) fired = 1;
      tick();
    end
    mem_wen = 1'b0;
    if (!fired) timeout("store");
  endtask

  task automatic fetch(input logic [31:0] a, output int t);
    bit fired = 0;
    t = 0;
    inst_addr = a; inst_req_valid = 1'b1;
    for (int k = 0; k < 64 && !fired; k++) begin
      @(negedge clk);
      if (inst_req_ready === 1'b1) begin fired = 1; t = cycle; end
      tick();
    end
    inst_req_valid = 1'b0;
    if (!fired) timeout("fetch");
  endtask

  task automatic load(input logic [31:0] a, output int t);
    bit fired = 0;
    t = 0;
    mem_addr = a; mem_ren = 1'b1;
    for (int k = 0; k < 64 && !fired; k++) begin
      @(negedge clk);
      if (mem_req_ready === 1'b1) begin fired = 1; t = cycle; end
      tick();
    end
    mem_ren = 1'b0;
    if (!fired) timeout("load");
  endtask

  // Returns at the falling edge of the first cycle the response is valid.
  task automatic wait_resp(input bit is_data, output logic [31:0] d, output int t);
    bit seen = 0;
    d = 32'h0; t = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (is_data ? (mem_rdata_valid === 1'b1) : (inst_valid === 1'b1)) begin
        seen = 1; t = cycle; d = is_data ? mem_rdata : inst_rdata;
      end
    end
    if (!seen) timeout(is_data ? "load_resp" : "fetch_resp");
  endtask

  function automatic logic [31:0] rand_addr(input bit aligned);
    logic [31:0] a;
    a = $urandom;
    a[ADDR_W+1:2] = ($urandom_range(0, 7) == 0) ? {ADDR_W{1'b1}} : ADDR_W'($urandom_range(0, 15));
    if (aligned) a[1:0] = 2'b00;
    return a;
  endfunction

  // ---------------- stimulus ----------------------------------------------
  initial begin
    int          t, v, cnt;
    logic [31:0] d;
    bit          both;
    for (int i = 0; i < WORDS; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    rst_n = 1'b0;
    inst_addr = '0; inst_req_valid = 0; inst_ready = 0;
    mem_addr = '0; mem_wen = 0; mem_wdata = '0; mem_wstrb = '0; mem_ren = 0;
    mem_rdata_ready = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("idle_inst_valid", inst_valid, 0);
    check("idle_inst_rdata", inst_rdata, 0);
    tick();

    // fetch of a preloaded word: latency and data
    store(32'h0000_0010, 32'h2402_0005, 4'hF);
    inst_ready = 1'b1; mem_rdata_ready = 1'b1;
    fetch(32'h0000_0010, t);
    wait_resp(1'b0, d, v);
    check("fetch_latency", 32'(v - t), 32'(LAT + 1));
    check("fetch_data", d, 32'h2402_0005);
    tick();

    // partial store then load back
    store(32'h0000_0040, 32'hAABB_CCDD, 4'b0011);
    load(32'h0000_0040, t);
    wait_resp(1'b1, d, v);
    check("load_latency", 32'(v - t), 32'(LAT + 1));
    check("load_partial", d, 32'h0000_CCDD);
    tick();

    // simultaneous fetch and load: load first, fetch in the next IDLE cycle
    inst_addr = 32'h0000_0010; inst_req_valid = 1'b1;
    mem_addr  = 32'h0000_0040; mem_ren = 1'b1;
    @(negedge clk);
    check("arb_load_granted", mem_req_ready, 1);
    check("arb_fetch_denied", inst_req_ready, 0);
    tick();
    mem_ren = 1'b0;
    wait_resp(1'b1, d, v);
    check("arb_load_data", d, 32'h0000_CCDD);
    tick();
    @(negedge clk);
    check("arb_fetch_next", inst_req_ready, 1);
    tick();
    inst_req_valid = 1'b0;
    wait_resp(1'b0, d, v);
    check("arb_fetch_data", d, 32'h2402_0005);
    tick();

    // response held for 5 cycles with inst_ready low
    inst_ready = 1'b0;
    fetch(32'h0000_0010, t);
    wait_resp(1'b0, d, v);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", inst_valid, 1);
      check("stall_data", inst_rdata, 32'h2402_0005);
    end
    tick();
    inst_ready = 1'b1; inst_req_valid = 1'b1; inst_addr = 32'h0000_0010;
    @(negedge clk);
    check("accept_cycle_valid", inst_valid, 1);
    check("accept_cycle_no_grant", inst_req_ready, 0);
    tick();
    @(negedge clk);
    check("idle_after_accept", inst_req_ready, 1);
    tick();
    inst_req_valid = 1'b0;
    wait_resp(1'b0, d, v);
    check("post_stall_data", d, 32'h2402_0005);
    tick();

    // reset while waiting: response dropped, next fetch served
    fetch(32'h0000_0040, t);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_sram_en", sram_en, 0);
    check("async_rst_inst_valid", inst_valid, 0);
    tick(); tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (inst_valid === 1'b1 || mem_rdata_valid === 1'b1) cnt++;
      tick();
    end
    check("no_resp_after_reset", 32'(cnt), 0);
    fetch(32'h0000_0040, t);
    wait_resp(1'b0, d, v);
    check("fetch_after_reset", d, 32'h0000_CCDD);
    tick();

    // random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      both            = ($urandom_range(0, 15) == 0);
      inst_req_valid  = 1'($urandom_range(0, 1));
      inst_addr       = rand_addr(1'b0);
      mem_addr        = rand_addr(1'b1);
      mem_wdata       = $urandom;
      mem_wstrb       = 4'($urandom_range(0, 15));
      mem_wen         = both || ($urandom_range(0, 5) == 0);
      mem_ren         = both || (!mem_wen && $urandom_range(0, 4) == 0);
      inst_ready      = ($urandom_range(0, 3) != 0);
      mem_rdata_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    inst_req_valid = 0; mem_wen = 0; mem_ren = 0;
    inst_ready = 1; mem_rdata_ready = 1;
    repeat (30) tick();

`ifdef BRIDGE_PERF_EN
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    inst_ready = 1'b0;
    mem_addr = 32'h0000_0100; mem_wdata = 32'h1234_5678; mem_wstrb = 4'hF; mem_wen = 1'b1;
    inst_addr = 32'h0000_0010; inst_req_valid = 1'b1;
    tick(); tick(); tick();
    mem_wen = 1'b0;
    tick();
    inst_req_valid = 1'b0;
    wait_resp(1'b0, d, v);
    tick();
    tick();
    inst_ready = 1'b1;
    tick();
    check("arb_stall_cnt", arb_stall_cnt, 32'd3);
    check("resp_stall_cnt", resp_stall_cnt, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
